freq_stream_packer: RTL and testbench

Downstream consumer of the frequency-selector output stream. Takes 80-bit selected samples with their 7-bit channel index, aligns capture to frame boundaries (index 0), buffers samples in a FIFO and serialises each into three 32-bit AXI-Stream words with `tlast` per frame, for a DMA to write to memory. Sits in the `dev_clk` domain directly after the frequency selector's `data_out`/`index_out`/`valid_out`.

---
 rtl/freq_stream_packer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_freq_stream_packer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_stream_packer.sv
// -----------------------------------------------------------------------------
// freq_stream_packer
//
// Packs the frequency-selector output stream (80-bit samples plus a 7-bit
// channel index) into 32-bit AXI-Stream words for a DMA engine. Capture is
// aligned to frame boundaries (channel index 0). Accepted samples pass through
// a small FIFO. Each sample then goes out as three words:
//   W0 = {8'hA5, sof, index[6:0], data[79:64]}
//   W1 = data[63:32]
//   W2 = data[31:0]   (tlast set on the last sample of a frame)
//
// Parameters
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 4)
//   FRAME_LEN   samples per frame (1..128)
//
// Ports
//   dev_clk, dev_rst_n   clock; synchronous active-low reset
//   enable               capture enable, only acted on at frame boundaries
//   clear_stats          one-cycle pulse that clears overflow/drop_count
//   data_in/index_in/valid_in   sample stream; the source cannot be stalled
//   m_axis_*             AXI-Stream master (tdata/tvalid/tready/tlast)
//   overflow             sticky; at least one sample dropped since last clear
//   drop_count           dropped samples, saturating at 16'hFFFF
//   frame_count          completed frames (tlast handshakes), wraps
//   cap_state_dbg        capture FSM state (0 idle, 1 wait_sof, 2 capture)
//   ser_state_dbg        serializer FSM state (0 idle, 1 W0, 2 W1, 3 W2)
//
// Handshake: a word transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both 1. Once tvalid is raised, tvalid, tdata and tlast
// hold their values until that transfer happens. Only reset clears them
// before the transfer. tvalid never depends on tready.
// -----------------------------------------------------------------------------
module freq_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 128
) (
  input  logic        dev_clk,
  input  logic        dev_rst_n,
  input  logic        enable,
  input  logic        clear_stats,
  input  logic [79:0] data_in,
  input  logic [6:0]  index_in,
  input  logic        valid_in,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count,
  output logic [1:0]  cap_state_dbg,
  output logic [1:0]  ser_state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Entry layout: [88] sof, [87] last, [86:80] index, [79:0] data.
  // The sof flag is kept in the entry so W0 does not have to recover the
  // position from the index. After WAIT_SOF the index is not meaningful.
  localparam int EW = 89;
  localparam logic [7:0] LAST_POS = 8'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_WAIT_SOF = 2'd1,
    CAP_CAPTURE  = 2'd2
  } cap_state_t;

  cap_state_t cap_state, cap_next;
  logic [7:0] pos, pos_next;      // position of the next sample within the frame
  logic       accept;
  logic       acc_sof;
  logic       acc_last;

  always_ff @(posedge dev_clk) begin
    if (!dev_rst_n) begin
      cap_state <= CAP_IDLE;
      pos       <= 8'd0;
    end else begin
      cap_state <= cap_next;
      pos       <= pos_next;
    end
  end

  always_comb begin
    cap_next = cap_state;
    pos_next = pos;
    accept   = 1'b0;
    acc_sof  = 1'b0;
    acc_last = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (enable) cap_next = CAP_WAIT_SOF;
      end
      CAP_WAIT_SOF: begin
        if (!enable) begin
          cap_next = CAP_IDLE;
        end else if (valid_in && (index_in == 7'd0)) begin
          accept  = 1'b1;
          acc_sof = 1'b1;
          if (LAST_POS == 8'd0) begin
            // A single-sample frame ends at its sof. enable is 1 here.
            acc_last = 1'b1;
            pos_next = 8'd0;
          end else begin
            cap_next = CAP_CAPTURE;
            pos_next = 8'd1;
          end
        end
      end
      CAP_CAPTURE: begin
        // Inside a frame every valid sample takes the next position. The
        // channel index and enable are not checked until the frame ends.
        if (valid_in) begin
          accept = 1'b1;
          if (pos == LAST_POS) begin
            acc_last = 1'b1;
            pos_next = 8'd0;
            cap_next = enable ? CAP_WAIT_SOF : CAP_IDLE;
          end else begin
            pos_next = pos + 8'd1;
          end
        end
      end
      default: begin
        cap_next = CAP_IDLE;
        pos_next = 8'd0;
      end
    endcase
  end

  assign cap_state_dbg = cap_state;

  // ---------------------------------------------------------------------------
  // Sample FIFO (pointers carry one extra wrap bit for full/empty)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          push, pop, drop;
  logic [EW-1:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // A pop on the same edge frees a slot, so a full FIFO can still take a
  // write when the serializer is reading.
  assign push = accept && (!fifo_full || pop);
  assign drop = accept && fifo_full && !pop;

  always_ff @(posedge dev_clk) begin
    if (!dev_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset. The pointers alone decide what is valid.
  always_ff @(posedge dev_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {acc_sof, acc_last, index_in, data_in};
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_W0   = 2'd1,
    SER_W1   = 2'd2,
    SER_W2   = 2'd3
  } ser_state_t;

  ser_state_t    ser_state, ser_next;
  logic [EW-1:0] hold_q;
  logic          hs;

  assign hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge dev_clk) begin
    if (!dev_rst_n) begin
      ser_state <= SER_IDLE;
      hold_q    <= '0;
    end else begin
      ser_state <= ser_next;
      if (pop) hold_q <= head;
    end
  end

  always_comb begin
    ser_next = ser_state;
    pop      = 1'b0;
    case (ser_state)
      SER_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          ser_next = SER_W0;
        end
      end
      SER_W0: if (hs) ser_next = SER_W1;
      SER_W1: if (hs) ser_next = SER_W2;
      SER_W2: begin
        if (hs) begin
          // Load the next entry straight into W0 so back-to-back samples
          // leave no idle cycle between them.
          if (!fifo_empty) begin
            pop      = 1'b1;
            ser_next = SER_W0;
          end else begin
            ser_next = SER_IDLE;
          end
        end
      end
      default: ser_next = SER_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata = 32'd0;
    m_axis_tlast = 1'b0;
    case (ser_state)
      SER_W0: m_axis_tdata = {8'hA5, hold_q[88], hold_q[86:80], hold_q[79:64]};
      SER_W1: m_axis_tdata = hold_q[63:32];
      SER_W2: begin
        m_axis_tdata = hold_q[31:0];
        m_axis_tlast = hold_q[87];
      end
      default: begin
        m_axis_tdata = 32'd0;
        m_axis_tlast = 1'b0;
      end
    endcase
  end

  assign m_axis_tvalid = (ser_state != SER_IDLE);
  assign ser_state_dbg = ser_state;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge dev_clk) begin
    if (!dev_rst_n) begin
      overflow    <= 1'b0;
      drop_count  <= 16'd0;
      frame_count <= 16'd0;
    end else begin
      // When a drop and a clear arrive together, the drop is kept. The clear
      // wipes the old count and this drop starts the new one.
      if (drop) begin
        overflow <= 1'b1;
        if (clear_stats)                drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (clear_stats) begin
        overflow   <= 1'b0;
        drop_count <= 16'd0;
      end
      if (hs && (ser_state == SER_W2) && hold_q[87])
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_freq_stream_packer.sv
// -----------------------------------------------------------------------------
// Testbench for freq_stream_packer (FIFO_DEPTH=16, FRAME_LEN=128).
// Stimulus tasks push the words each test expects into exp_q. A monitor runs
// on the falling edge. It pops and compares every word that is about to
// transfer. It also checks that a stalled word stays unchanged.
// -----------------------------------------------------------------------------
module tb_freq_stream_packer;

  logic        dev_clk = 1'b0;
  logic        dev_rst_n;
  logic        enable;
  logic        clear_stats;
  logic [79:0] data_in;
  logic [6:0]  index_in;
  logic        valid_in;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] frame_count;
  logic [1:0]  cap_state_dbg;
  logic [1:0]  ser_state_dbg;

  freq_stream_packer #(.FIFO_DEPTH(16), .FRAME_LEN(128)) dut (
    .dev_clk       (dev_clk),
    .dev_rst_n     (dev_rst_n),
    .enable        (enable),
    .clear_stats   (clear_stats),
    .data_in       (data_in),
    .index_in      (index_in),
    .valid_in      (valid_in),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .frame_count   (frame_count),
    .cap_state_dbg (cap_state_dbg),
    .ser_state_dbg (ser_state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 dev_clk = ~dev_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];          // {tlast, tdata}

  logic        rand_ready  = 1'b0;
  logic        ready_fixed = 1'b1;

  // tready is driven 2 ns after each rising edge. Test code changes
  // ready_fixed at 1 ns, so a new setting takes effect in the same cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge dev_clk);
      #2;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      else            m_axis_tready = ready_fixed;
    end
  end

  // ---------------- monitor ----------------
  logic        stall_prev = 1'b0;
  logic [32:0] prev_word  = '0;

  always @(negedge dev_clk) begin
    if (dev_rst_n) begin
      if (stall_prev) begin
        checks++;
        if (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} != prev_word)) begin
          failures++;
          $display("FAIL hold: got tvalid=%0b word=%h required tvalid=1 word=%h",
                   m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_word);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected: got word=%h required none",
                   {m_axis_tlast, m_axis_tdata});
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            failures++;
            $display("FAIL word: got tlast=%0b tdata=%h required tlast=%0b tdata=%h",
                     m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge dev_clk);
      #1;
    end
  endtask

  function automatic logic [79:0] mk(input int i);
    logic [15:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = 16'h1000 + 16'(i);
    b = 32'hCAFE_0000 | 32'(i);
    c = 32'h00C0_0000 + 32'(i * 3);
    return {a, b, c};
  endfunction

  task automatic push_exp(input logic [79:0] d, input logic [6:0] idx,
                          input logic sof, input logic last);
    exp_q.push_back({1'b0, 8'hA5, sof, idx, d[79:64]});
    exp_q.push_back({1'b0, d[63:32]});
    exp_q.push_back({last, d[31:0]});
  endtask

  task automatic send(input logic [79:0] d, input logic [6:0] idx);
    data_in  = d;
    index_in = idx;
    valid_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  task automatic do_reset();
    exp_q.delete();
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    dev_rst_n   = 1'b0;
    enable      = 1'b0;
    clear_stats = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;
    index_in    = '0;
    tick(2);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tdata",  m_axis_tdata,       32'd0);
    chk("rst_overflow",    32'(overflow),    32'd0);
    chk("rst_drop_count",  32'(drop_count),  32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_cap_state",   32'(cap_state_dbg), 32'd0);
    chk("rst_ser_state",   32'(ser_state_dbg), 32'd0);
    dev_rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [79:0] d;
    dev_rst_n   = 1'b0;
    enable      = 1'b0;
    clear_stats = 1'b0;
    valid_in    = 1'b0;
    data_in     = '0;
    index_in    = '0;

    // 1: samples before index 0 are ignored, then one full frame
    do_reset();
    enable = 1'b1;
    tick(2);
    for (int k = 5; k <= 8; k++) begin
      send(mk(900 + k), 7'(k));
      tick(3);
    end
    for (int i = 0; i < 128; i++) begin
      d = mk(i);
      push_exp(d, 7'(i), i == 0, i == 127);
      send(d, 7'(i));
      tick(3);
    end
    drain(2000);
    chk("t1_frame_count", 32'(frame_count), 32'd1);
    chk("t1_drop_count",  32'(drop_count),  32'd0);
    chk("t1_cap_state",   32'(cap_state_dbg), 32'd1);   // enable still 1 -> WAIT_SOF

    // 2: single sample, latency and exact word values
    do_reset();
    enable = 1'b1;
    tick(2);
    d = 80'h1234_89ABCDEF_01234567;
    exp_q.push_back({1'b0, 32'hA580_1234});
    exp_q.push_back({1'b0, 32'h89AB_CDEF});
    exp_q.push_back({1'b0, 32'h0123_4567});
    send(d, 7'd0);                           // written at this edge
    chk("t2_tvalid_at_write", 32'(m_axis_tvalid), 32'd0);
    tick(1);
    chk("t2_tvalid_next", 32'(m_axis_tvalid), 32'd1);
    chk("t2_w0", m_axis_tdata, 32'hA580_1234);
    drain(50);

    // 3: overflow with a stalled sink, then clear_stats
    do_reset();
    enable      = 1'b1;
    ready_fixed = 1'b0;
    tick(2);
    for (int i = 0; i < 21; i++) begin
      d = mk(200 + i);
      // The first sample is in the holding register and 16 fill the FIFO.
      // The last 4 are dropped.
      if (i <= 16) push_exp(d, 7'(i), i == 0, 1'b0);
      send(d, 7'(i));
    end
    tick(2);
    d = mk(200);
    chk("t3_w0_frozen", m_axis_tdata, {8'hA5, 1'b1, 7'd0, d[79:64]});
    chk("t3_overflow",   32'(overflow),   32'd1);
    chk("t3_drop_count", 32'(drop_count), 32'd4);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    chk("t3_overflow_clr",   32'(overflow),   32'd0);
    chk("t3_drop_count_clr", 32'(drop_count), 32'd0);
    ready_fixed = 1'b1;
    drain(300);

    // 4: random tready across three frames
    do_reset();
    enable     = 1'b1;
    rand_ready = 1'b1;
    tick(2);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 128; i++) begin
        d = mk(1000 + f * 128 + i);
        push_exp(d, 7'(i), i == 0, i == 127);
        send(d, 7'(i));
        tick(7);
      end
    end
    drain(5000);
    rand_ready = 1'b0;
    tick(2);
    chk("t4_frame_count", 32'(frame_count), 32'd3);
    chk("t4_drop_count",  32'(drop_count),  32'd0);

    // 5: enable dropped mid-frame; the frame still completes, then idle
    do_reset();
    enable = 1'b1;
    tick(2);
    for (int i = 0; i < 128; i++) begin
      if (i == 40) enable = 1'b0;
      d = mk(3000 + i);
      push_exp(d, 7'(i), i == 0, i == 127);
      send(d, 7'(i));
      tick(3);
    end
    chk("t5_cap_idle", 32'(cap_state_dbg), 32'd0);
    send(mk(4000), 7'd0);                    // must be ignored
    drain(2000);
    tick(5);
    chk("t5_frame_count", 32'(frame_count), 32'd1);

    // 6: reset while W1 is presented
    do_reset();
    enable      = 1'b1;
    ready_fixed = 1'b0;
    tick(2);
    d = mk(77);
    push_exp(d, 7'd0, 1'b1, 1'b0);
    send(d, 7'd0);
    tick(2);
    ready_fixed = 1'b1;
    tick(1);                                 // W0 transfers at this edge
    ready_fixed = 1'b0;
    chk("t6_in_w1", 32'(ser_state_dbg), 32'd2);
    dev_rst_n = 1'b0;
    enable    = 1'b0;
    exp_q.delete();
    tick(1);
    chk("t6_tvalid",      32'(m_axis_tvalid), 32'd0);
    chk("t6_frame_count", 32'(frame_count),   32'd0);
    chk("t6_drop_count",  32'(drop_count),    32'd0);
    chk("t6_overflow",    32'(overflow),      32'd0);
    dev_rst_n   = 1'b1;
    enable      = 1'b1;
    ready_fixed = 1'b1;
    tick(2);
    d = mk(88);
    push_exp(d, 7'd0, 1'b1, 1'b0);
    send(d, 7'd0);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
